// File: rtl/uart_apb_scheduler.sv
// APB master that polls a UART status register and schedules RX reads and
// round-robin TX writes from two byte requesters, with an ACCESS-phase timeout.
module uart_apb_scheduler #(
   parameter logic [3:0] ADDR_TXDATA = 4'h0,
   parameter logic [3:0] ADDR_RXDATA = 4'h4,
   parameter logic [3:0] ADDR_STATUS = 4'h8,
   parameter int         POLL_PERIOD = 16,
   parameter int         TIMEOUT     = 64
) (
   input  logic        PCLK,
   input  logic        PRESET,
   output logic [3:0]  PADDR,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        tx0_valid,
   input  logic [7:0]  tx0_data,
   output logic        tx0_ready,
   input  logic        tx1_valid,
   input  logic [7:0]  tx1_data,
   output logic        tx1_ready,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic        err_timeout,
   output logic [2:0]  state_dbg
);

   // Handshakes: a byte moves on any cycle where valid && ready are both high
   // at the rising PCLK edge; the producer holds valid and data stable until then.

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      DECIDE    = 3'd3,
      RX_SETUP  = 3'd4,
      RX_ACCESS = 3'd5,
      TX_SETUP  = 3'd6,
      TX_ACCESS = 3'd7
   } state_t;

   state_t          state;
   logic [7:0]      poll_cnt;
   logic [TW-1:0]   to_cnt;
   logic [1:0]      status_q;
   logic            rx_room_q;
   logic            rr_ptr;
   logic            in_access;
   logic            any_tx;
   logic            gnt0;
   logic            gnt1;
   logic            rx_room;
   logic            unused_prdata;

   assign state_dbg     = state;
   assign in_access     = (state == ST_ACCESS) || (state == RX_ACCESS) || (state == TX_ACCESS);
   assign any_tx        = tx0_valid || tx1_valid;
   // rr_ptr=1 favours requester 1 when both are valid
   assign gnt1          = tx1_valid && (!tx0_valid || rr_ptr);
   assign gnt0          = tx0_valid && !gnt1;
   // The buffer counts as empty if it is being drained on this same edge
   assign rx_room       = !rx_valid || rx_ready;
   assign unused_prdata = ^PRDATA[31:8];

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state       <= IDLE;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= 4'h0;
         PWDATA      <= 32'h0;
         tx0_ready   <= 1'b0;
         tx1_ready   <= 1'b0;
         rx_valid    <= 1'b0;
         rx_data     <= 8'h0;
         err_timeout <= 1'b0;
         poll_cnt    <= 8'h0;
         to_cnt      <= '0;
         status_q    <= 2'b00;
         rx_room_q   <= 1'b0;
         rr_ptr      <= 1'b0;
      end else begin
         err_timeout <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;

         if (in_access && !PREADY) begin
            // Slave stalled too long: drop the transfer, including any latched TX byte
            if (to_cnt == TW'(TIMEOUT - 1)) begin
               PSEL        <= 1'b0;
               PENABLE     <= 1'b0;
               PWRITE      <= 1'b0;
               PWDATA      <= 32'h0;
               err_timeout <= 1'b1;
               state       <= IDLE;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end else begin
            case (state)
               IDLE: begin
                  if (any_tx || poll_cnt == 8'(POLL_PERIOD - 1)) begin
                     poll_cnt <= 8'h0;
                     PSEL     <= 1'b1;
                     PENABLE  <= 1'b0;
                     PADDR    <= ADDR_STATUS;
                     PWRITE   <= 1'b0;
                     PWDATA   <= 32'h0;
                     state    <= ST_SETUP;
                  end else begin
                     poll_cnt <= poll_cnt + 8'd1;
                  end
               end
               ST_SETUP: begin
                  PENABLE <= 1'b1;
                  to_cnt  <= '0;
                  state   <= ST_ACCESS;
               end
               ST_ACCESS: begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  status_q  <= PRDATA[1:0];
                  rx_room_q <= rx_room;
                  state     <= DECIDE;
                  // Grant is issued here so the registered ready is high during DECIDE
                  if (!(PRDATA[0] && rx_room) && !PRDATA[1] && any_tx) begin
                     tx0_ready <= gnt0;
                     tx1_ready <= gnt1;
                     rr_ptr    <= gnt0;
                  end
               end
               DECIDE: begin
                  tx0_ready <= 1'b0;
                  tx1_ready <= 1'b0;
                  if (status_q[0] && rx_room_q) begin
                     PSEL   <= 1'b1;
                     PADDR  <= ADDR_RXDATA;
                     PWRITE <= 1'b0;
                     PWDATA <= 32'h0;
                     state  <= RX_SETUP;
                  end else if (!status_q[1] && (tx0_ready || tx1_ready)) begin
                     PSEL   <= 1'b1;
                     PADDR  <= ADDR_TXDATA;
                     PWRITE <= 1'b1;
                     PWDATA <= {24'h0, (tx0_ready ? tx0_data : tx1_data)};
                     state  <= TX_SETUP;
                  end else begin
                     state <= IDLE;
                  end
               end
               RX_SETUP: begin
                  PENABLE <= 1'b1;
                  to_cnt  <= '0;
                  state   <= RX_ACCESS;
               end
               RX_ACCESS: begin
                  PSEL     <= 1'b0;
                  PENABLE  <= 1'b0;
                  rx_valid <= 1'b1;
                  rx_data  <= PRDATA[7:0];
                  state    <= IDLE;
               end
               TX_SETUP: begin
                  PENABLE <= 1'b1;
                  to_cnt  <= '0;
                  state   <= TX_ACCESS;
               end
               TX_ACCESS: begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  PWRITE  <= 1'b0;
                  PWDATA  <= 32'h0;
                  state   <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
